// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I instruction decode stage. Sits directly downstream of fetch and
// feeds the execute stage through a registered ID/EX boundary.
//
//   * Decodes the fetched instruction into an immediate, register indices,
//     function fields and the control bundle for EX/MEM/WB.
//   * Holds the 32 x 32 architectural register file. The write port is
//     driven from writeback; same-cycle writes are bypassed to the operands.
//   * Detects load-use hazards against the instruction currently in EX and
//     raises a combinational stall towards fetch, inserting a bubble.
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous, active-high reset
//   ID_instruction_i     instruction word from the IF/ID register
//   ID_pc_i              PC of that instruction
//   ID_pc_plus4_i        PC + 4 of that instruction
//   ID_valid_i           instruction inputs carry a real instruction
//   ID_flush_i           taken branch/jump: squash the current decode
//   EX_mem_read_i        instruction in EX is a load
//   EX_rd_addr_i         destination register of the instruction in EX
//   WB_reg_write_i       writeback write enable
//   WB_rd_addr_i         writeback destination register
//   WB_rd_data_i         writeback data
//   ID_stall_o           load-use stall (combinational): fetch holds PC and IF/ID
//   ID_*_o (others)      registered ID/EX outputs, valid one cycle after input
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [DATA_WIDTH-1:0]     ID_instruction_i,
    input  logic [DATA_WIDTH-1:0]     ID_pc_i,
    input  logic [DATA_WIDTH-1:0]     ID_pc_plus4_i,
    input  logic                      ID_valid_i,
    input  logic                      ID_flush_i,

    input  logic                      EX_mem_read_i,
    input  logic [REG_ADDR_WIDTH-1:0] EX_rd_addr_i,

    input  logic                      WB_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] WB_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     WB_rd_data_i,

    output logic                      ID_stall_o,

    output logic [DATA_WIDTH-1:0]     ID_pc_o,
    output logic [DATA_WIDTH-1:0]     ID_pc_plus4_o,
    output logic [DATA_WIDTH-1:0]     ID_rs1_data_o,
    output logic [DATA_WIDTH-1:0]     ID_rs2_data_o,
    output logic [DATA_WIDTH-1:0]     ID_imm_o,
    output logic [REG_ADDR_WIDTH-1:0] ID_rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] ID_rs2_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] ID_rd_addr_o,
    output logic [2:0]                ID_funct3_o,
    output logic                      ID_funct7b5_o,
    output logic [6:0]                ID_opcode_o,
    output logic                      ID_alu_src_o,
    output logic                      ID_reg_write_o,
    output logic                      ID_mem_read_o,
    output logic                      ID_mem_write_o,
    output logic                      ID_branch_o,
    output logic                      ID_jump_o,
    output logic                      ID_illegal_o,
    output logic                      ID_valid_o
);

    // -----------------------------------------------------------------------
    // Types
    // -----------------------------------------------------------------------
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs1_addr;
        logic [REG_ADDR_WIDTH-1:0] rs2_addr;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic [2:0]                funct3;
        logic                      funct7b5;
        logic [6:0]                opcode;
        ctrl_t                     ctrl;
        logic                      illegal;
        logic                      valid;
    } id_ex_t;

    // -----------------------------------------------------------------------
    // Instruction fields
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]     instr;
    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;

    assign instr    = ID_instruction_i;
    assign opcode   = instr[6:0];
    assign rd_addr  = instr[11:7];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // Immediate candidates, all sign-extended from instr[31].
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] imm_j;

    assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(DATA_WIDTH-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    // -----------------------------------------------------------------------
    // Opcode decode: immediate select, control bundle, operand usage
    // -----------------------------------------------------------------------
    ctrl_t                 dec_ctrl;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_illegal;
    logic                  rs1_used;
    logic                  rs2_used;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case; a path that leaves one unassigned would infer a latch.
        dec_ctrl    = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        rs1_used    = 1'b1;
        rs2_used    = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_ctrl.reg_write = 1'b1;
                rs2_used           = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_imm            = imm_i;
            end
            OPC_LOAD: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_imm            = imm_i;
            end
            OPC_STORE: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_imm            = imm_s;
                rs2_used           = 1'b1;
            end
            OPC_BRANCH: begin
                dec_ctrl.branch    = 1'b1;
                dec_imm            = imm_b;
                rs2_used           = 1'b1;
            end
            OPC_JAL: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_imm            = imm_j;
                rs1_used           = 1'b0;
            end
            OPC_JALR: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_imm            = imm_i;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_imm            = imm_u;
                rs1_used           = 1'b0;
            end
            default: begin
                // Unsupported opcode: travels down the pipe as a valid
                // instruction flagged illegal, with every control cleared.
                dec_illegal = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wb_write_en;

    // x0 is hardwired to zero, so writes addressed to it are dropped here.
    assign wb_write_en = WB_reg_write_i && (WB_rd_addr_i != '0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values, independent of the
        // order in which always_ff blocks are evaluated.
        if (rst) begin
            // NOTE: the register array is cleared on reset because software
            // may rely on registers reading zero; this costs a reset on every
            // storage bit and rules out mapping the array onto a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_write_en) begin
            regs_q[WB_rd_addr_i] <= WB_rd_data_i;
        end
    end

    // Operand read with writeback bypass: a write landing on this edge is
    // not yet in the array, so the decode sees the writeback data directly.
    function automatic logic [DATA_WIDTH-1:0] read_operand(
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0]     stored
    );
        logic [DATA_WIDTH-1:0] value;
        if (addr == '0) begin
            value = '0;
        end else if (wb_write_en && (WB_rd_addr_i == addr)) begin
            value = WB_rd_data_i;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    assign rs1_data = read_operand(rs1_addr, regs_q[rs1_addr]);
    assign rs2_data = read_operand(rs2_addr, regs_q[rs2_addr]);

    // -----------------------------------------------------------------------
    // Load-use hazard and bubble insertion
    // -----------------------------------------------------------------------
    logic rs1_hazard;
    logic rs2_hazard;
    logic load_use;
    logic bubble;

    assign rs1_hazard = rs1_used && (EX_rd_addr_i == rs1_addr);
    assign rs2_hazard = rs2_used && (EX_rd_addr_i == rs2_addr);
    assign load_use   = ID_valid_i && EX_mem_read_i && (EX_rd_addr_i != '0)
                        && (rs1_hazard || rs2_hazard);

    // A flush discards the instruction anyway, so it must not also freeze
    // fetch: the redirect has to be taken on this cycle.
    assign ID_stall_o = load_use && !ID_flush_i;

    // Fetch re-presents a stalled instruction next cycle; this cycle only a
    // bubble moves into EX.
    assign bubble = ID_flush_i || load_use || !ID_valid_i;

    // -----------------------------------------------------------------------
    // ID/EX pipeline register
    // -----------------------------------------------------------------------
    id_ex_t id_ex_d;
    id_ex_t id_ex_q;

    always_comb begin
        id_ex_d          = '0;
        id_ex_d.pc       = ID_pc_i;
        id_ex_d.pc_plus4 = ID_pc_plus4_i;
        id_ex_d.rs1_data = rs1_data;
        id_ex_d.rs2_data = rs2_data;
        id_ex_d.imm      = dec_imm;
        id_ex_d.rs1_addr = rs1_addr;
        id_ex_d.rs2_addr = rs2_addr;
        id_ex_d.rd_addr  = rd_addr;
        id_ex_d.funct3   = instr[14:12];
        id_ex_d.funct7b5 = instr[30];
        id_ex_d.opcode   = opcode;
        // Data fields are left as decoded in a bubble; only the qualifiers
        // that make EX act on the slot are cleared.
        id_ex_d.ctrl     = bubble ? '0 : dec_ctrl;
        id_ex_d.illegal  = !bubble && dec_illegal;
        id_ex_d.valid    = !bubble;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ID_pc_o        = id_ex_q.pc;
    assign ID_pc_plus4_o  = id_ex_q.pc_plus4;
    assign ID_rs1_data_o  = id_ex_q.rs1_data;
    assign ID_rs2_data_o  = id_ex_q.rs2_data;
    assign ID_imm_o       = id_ex_q.imm;
    assign ID_rs1_addr_o  = id_ex_q.rs1_addr;
    assign ID_rs2_addr_o  = id_ex_q.rs2_addr;
    assign ID_rd_addr_o   = id_ex_q.rd_addr;
    assign ID_funct3_o    = id_ex_q.funct3;
    assign ID_funct7b5_o  = id_ex_q.funct7b5;
    assign ID_opcode_o    = id_ex_q.opcode;
    assign ID_alu_src_o   = id_ex_q.ctrl.alu_src;
    assign ID_reg_write_o = id_ex_q.ctrl.reg_write;
    assign ID_mem_read_o  = id_ex_q.ctrl.mem_read;
    assign ID_mem_write_o = id_ex_q.ctrl.mem_write;
    assign ID_branch_o    = id_ex_q.ctrl.branch;
    assign ID_jump_o      = id_ex_q.ctrl.jump;
    assign ID_illegal_o   = id_ex_q.illegal;
    assign ID_valid_o     = id_ex_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage. Inputs are driven on the falling
// edge, the combinational stall is sampled just after driving, and the
// registered outputs are sampled 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ID_instruction_i;
    logic [31:0] ID_pc_i;
    logic [31:0] ID_pc_plus4_i;
    logic        ID_valid_i;
    logic        ID_flush_i;
    logic        EX_mem_read_i;
    logic [4:0]  EX_rd_addr_i;
    logic        WB_reg_write_i;
    logic [4:0]  WB_rd_addr_i;
    logic [31:0] WB_rd_data_i;

    logic        ID_stall_o;
    logic [31:0] ID_pc_o;
    logic [31:0] ID_pc_plus4_o;
    logic [31:0] ID_rs1_data_o;
    logic [31:0] ID_rs2_data_o;
    logic [31:0] ID_imm_o;
    logic [4:0]  ID_rs1_addr_o;
    logic [4:0]  ID_rs2_addr_o;
    logic [4:0]  ID_rd_addr_o;
    logic [2:0]  ID_funct3_o;
    logic        ID_funct7b5_o;
    logic [6:0]  ID_opcode_o;
    logic        ID_alu_src_o;
    logic        ID_reg_write_o;
    logic        ID_mem_read_o;
    logic        ID_mem_write_o;
    logic        ID_branch_o;
    logic        ID_jump_o;
    logic        ID_illegal_o;
    logic        ID_valid_o;

    decode_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ID_instruction_i (ID_instruction_i),
        .ID_pc_i          (ID_pc_i),
        .ID_pc_plus4_i    (ID_pc_plus4_i),
        .ID_valid_i       (ID_valid_i),
        .ID_flush_i       (ID_flush_i),
        .EX_mem_read_i    (EX_mem_read_i),
        .EX_rd_addr_i     (EX_rd_addr_i),
        .WB_reg_write_i   (WB_reg_write_i),
        .WB_rd_addr_i     (WB_rd_addr_i),
        .WB_rd_data_i     (WB_rd_data_i),
        .ID_stall_o       (ID_stall_o),
        .ID_pc_o          (ID_pc_o),
        .ID_pc_plus4_o    (ID_pc_plus4_o),
        .ID_rs1_data_o    (ID_rs1_data_o),
        .ID_rs2_data_o    (ID_rs2_data_o),
        .ID_imm_o         (ID_imm_o),
        .ID_rs1_addr_o    (ID_rs1_addr_o),
        .ID_rs2_addr_o    (ID_rs2_addr_o),
        .ID_rd_addr_o     (ID_rd_addr_o),
        .ID_funct3_o      (ID_funct3_o),
        .ID_funct7b5_o    (ID_funct7b5_o),
        .ID_opcode_o      (ID_opcode_o),
        .ID_alu_src_o     (ID_alu_src_o),
        .ID_reg_write_o   (ID_reg_write_o),
        .ID_mem_read_o    (ID_mem_read_o),
        .ID_mem_write_o   (ID_mem_write_o),
        .ID_branch_o      (ID_branch_o),
        .ID_jump_o        (ID_jump_o),
        .ID_illegal_o     (ID_illegal_o),
        .ID_valid_o       (ID_valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Controls packed as {alu_src, reg_write, mem_read, mem_write, branch, jump}.
    function automatic logic [5:0] ctl_bus();
        return {ID_alu_src_o, ID_reg_write_o, ID_mem_read_o,
                ID_mem_write_o, ID_branch_o, ID_jump_o};
    endfunction

    task automatic idle_inputs();
        ID_instruction_i = 32'h0;
        ID_pc_i          = 32'h0;
        ID_pc_plus4_i    = 32'h0;
        ID_valid_i       = 1'b0;
        ID_flush_i       = 1'b0;
        EX_mem_read_i    = 1'b0;
        EX_rd_addr_i     = 5'd0;
        WB_reg_write_i   = 1'b0;
        WB_rd_addr_i     = 5'd0;
        WB_rd_data_i     = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pc"},      ID_pc_o,       32'h0);
        check({tag, " pc4"},     ID_pc_plus4_o, 32'h0);
        check({tag, " rs1d"},    ID_rs1_data_o, 32'h0);
        check({tag, " rs2d"},    ID_rs2_data_o, 32'h0);
        check({tag, " imm"},     ID_imm_o,      32'h0);
        check({tag, " fields"},  {6'b0, ID_rs1_addr_o, ID_rs2_addr_o, ID_rd_addr_o,
                                  ID_funct3_o, ID_funct7b5_o, ID_opcode_o}, 32'h0);
        check({tag, " ctl"},     {24'b0, ctl_bus(), ID_illegal_o, ID_valid_o}, 32'h0);
        check({tag, " stall"},   {31'b0, ID_stall_o}, 32'h0);
    endtask

    // Decode "add x0, x<a>, x<b>" with writeback idle; check both operands.
    task automatic read_pair(input int a, input int b,
                             input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input string tag);
        @(negedge clk);
        idle_inputs();
        ID_instruction_i = {7'b0, 5'(b), 5'(a), 3'b0, 5'b0, 7'h33};
        ID_valid_i       = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("%s rs1 x%0d", tag, a), ID_rs1_data_o, exp_a);
        check($sformatf("%s rs2 x%0d", tag, b), ID_rs2_data_o, exp_b);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        flush;
        logic        ex_mr;
        logic [4:0]  ex_rd;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        e_stall;
        logic        e_valid;
        logic [5:0]  e_ctl;
        logic        e_ill;
        logic        chk;      // compare data fields (not a bubble)
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_imm;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    initial begin
        // Fields: instr, valid, flush, ex_mr, ex_rd, wb_we, wb_rd, wb_data,
        //         e_stall, e_valid, e_ctl, e_ill, chk, e_rs1, e_rs2, e_imm
        // Register file starts all-zero (after reset) at vector 0.
        // 0: WB writes x5 while decode input is invalid -> bubble
        vecs[0]  = '{32'h0042A483, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        // 1: add x6,x5,x0 reads the written x5
        vecs[1]  = '{32'h00028333, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0};
        // 2: addi x8,x7,-1 while WB writes x7 (bypass)
        vecs[2]  = '{32'hFFF38413, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd7, 32'h12345678, 1'b0, 1'b1, 6'b110000, 1'b0, 1'b1, 32'h12345678, 32'h0, 32'hFFFFFFFF};
        // 3: WB writes x0=5 while decoding add x6,x0,x0 -> no bypass for x0
        vecs[3]  = '{32'h00000333, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd0, 32'h5, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
        // 4: x0 still reads 0 afterwards
        vecs[4]  = '{32'h00000333, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
        // 5: sub x10,x5,x7 -> x7 was committed by vector 2
        vecs[5]  = '{32'h40728533, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'h0};
        // 6: load-use on rs1 (EX load to x5)
        vecs[6]  = '{32'h00028333, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        // 7: same instruction re-presented after the load moved on
        vecs[7]  = '{32'h00028333, 1'b1, 1'b0, 1'b0, 5'd5,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0};
        // 8: load-use on rs2 (add x6,x0,x5)
        vecs[8]  = '{32'h00500333, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        // 9: EX load to x0 never stalls, even though rs1=rs2=x0
        vecs[9]  = '{32'h00000333, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
        // 10: addi rs2 field (x31) matches EX rd, but rs2 unused -> no stall
        vecs[10] = '{32'hFFF38413, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b110000, 1'b0, 1'b1, 32'h12345678, 32'h0, 32'hFFFFFFFF};
        // 11: lui x5,0x28 (rs1 field = 5) with EX load to x5 -> no stall
        vecs[11] = '{32'h000282B7, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b110000, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'h00028000};
        // 12: flush together with a load-use hazard
        vecs[12] = '{32'h00028333, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        // 13: beq x0,x0,-4
        vecs[13] = '{32'hFE000EE3, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b000010, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFFFFFC};
        // 14: jal x1,+2048
        vecs[14] = '{32'h001000EF, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b010001, 1'b0, 1'b1, 32'h0, 32'h0, 32'h00000800};
        // 15: jalr x1,0(x5)
        vecs[15] = '{32'h000280E7, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b110001, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0};
        // 16: sw x7,-8(x0)
        vecs[16] = '{32'hFE702C23, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b100100, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'hFFFFFFF8};
        // 17: lw x9,4(x5)
        vecs[17] = '{32'h0042A483, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b111000, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'h00000004};
        // 18: auipc x3,0xFFFFF
        vecs[18] = '{32'hFFFFF197, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b110000, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFFF000};
        // 19: addi x0,x0,0 -> reg_write still driven for rd=0
        vecs[19] = '{32'h00000013, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b110000, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
        // 20: opcode 0x7F -> illegal, still valid
        vecs[20] = '{32'h0000007F, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'b000000, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
        // 21: same opcode but invalid input -> bubble clears illegal
        vecs[21] = '{32'h0000007F, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        // 22: store whose rs2 (x7) is being loaded in EX -> stall
        vecs[22] = '{32'hFE702C23, 1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    end

    initial begin
        idle_inputs();
        rst = 1'b1;

        // ---- reset then idle --------------------------------------------
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // ---- fill x1..x31 with a pattern, then read it back -------------
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            idle_inputs();
            WB_reg_write_i = 1'b1;
            WB_rd_addr_i   = 5'(i);
            WB_rd_data_i   = 32'hA5000000 + 32'(i);
        end
        for (int i = 1; i < 32; i++) begin
            read_pair(i, (i % 31) + 1,
                      32'hA5000000 + 32'(i), 32'hA5000000 + 32'((i % 31) + 1), "fill");
        end

        // ---- reset dominates a valid decode and a writeback -------------
        @(negedge clk);
        idle_inputs();
        rst              = 1'b1;
        ID_instruction_i = 32'h0042A483;
        ID_pc_i          = 32'h00000040;
        ID_pc_plus4_i    = 32'h00000044;
        ID_valid_i       = 1'b1;
        WB_reg_write_i   = 1'b1;
        WB_rd_addr_i     = 5'd9;
        WB_rd_data_i     = 32'hFFFF0000;
        repeat (2) @(posedge clk);
        #1;
        check({31'b0, ID_valid_o}, 32'h0, 32'h0 | {31'b0, ID_valid_o}) ;
        check_all_zero("rst_busy");
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        // x1..x31 must all read zero after reset, including the x9 write
        // attempted while reset was asserted.
        for (int i = 1; i < 32; i++) begin
            read_pair(i, (i % 31) + 1, 32'h0, 32'h0, "clr");
        end

        // ---- directed vector table ---------------------------------------
        for (int i = 0; i < NV; i++) begin
            logic [31:0] ins;
            logic [31:0] pc;
            ins = vecs[i].instr;
            pc  = 32'h00001000 + 32'(4 * i);

            @(negedge clk);
            ID_instruction_i = ins;
            ID_pc_i          = pc;
            ID_pc_plus4_i    = pc + 32'd4;
            ID_valid_i       = vecs[i].valid;
            ID_flush_i       = vecs[i].flush;
            EX_mem_read_i    = vecs[i].ex_mr;
            EX_rd_addr_i     = vecs[i].ex_rd;
            WB_reg_write_i   = vecs[i].wb_we;
            WB_rd_addr_i     = vecs[i].wb_rd;
            WB_rd_data_i     = vecs[i].wb_data;
            #1;
            check($sformatf("v%0d stall", i), {31'b0, ID_stall_o}, {31'b0, vecs[i].e_stall});

            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i),   {31'b0, ID_valid_o},   {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d ctl", i),     {26'b0, ctl_bus()},    {26'b0, vecs[i].e_ctl});
            check($sformatf("v%0d illegal", i), {31'b0, ID_illegal_o}, {31'b0, vecs[i].e_ill});
            if (vecs[i].chk) begin
                check($sformatf("v%0d rs1d", i),   ID_rs1_data_o, vecs[i].e_rs1);
                check($sformatf("v%0d rs2d", i),   ID_rs2_data_o, vecs[i].e_rs2);
                check($sformatf("v%0d imm", i),    ID_imm_o,      vecs[i].e_imm);
                check($sformatf("v%0d pc", i),     ID_pc_o,       pc);
                check($sformatf("v%0d pc4", i),    ID_pc_plus4_o, pc + 32'd4);
                check($sformatf("v%0d fields", i),
                      {6'b0, ID_rs1_addr_o, ID_rs2_addr_o, ID_rd_addr_o,
                       ID_funct3_o, ID_funct7b5_o, ID_opcode_o},
                      {6'b0, ins[19:15], ins[24:20], ins[11:7],
                       ins[14:12], ins[30], ins[6:0]});
            end
        end

        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("final idle valid", {31'b0, ID_valid_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
